// File: rtl/midi_note_parser.sv
// MIDI receive parser: channel-voice decode with running status, real-time passthrough, channel filter.
// Latency: events/strobes registered one cycle after the rx_valid carrying the completing byte.
// Backpressure: none, one byte per rx_valid strobe is always consumed; MIDI_TIMEOUT_EN adds mid-message abort.
module midi_note_parser #(
    parameter logic [3:0]  CHANNEL        = 4'd0,
    parameter bit          OMNI           = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic       gate,
    output logic [6:0] gate_note,
    output logic       msg_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] status_q, status_d;
    logic [6:0] d1_q, d1_d;

    logic byte_sys, byte_status, byte_data;
    logic one_byte_msg, note_msg, chan_ok;
    logic timeout_hit;
    logic ev_note, ev_on, ev_off, ev_err;

    // F8..FF real-time bytes fall through every class below and leave the parser untouched.
    assign byte_sys     = rx_valid && (rx_byte[7:3] == 5'b11110);
    assign byte_status  = rx_valid && rx_byte[7] && (rx_byte[7:4] != 4'hF);
    assign byte_data    = rx_valid && !rx_byte[7];

    assign one_byte_msg = (status_q[7:5] == 3'b110);
    assign note_msg     = (status_q[7:5] == 3'b100);
    assign chan_ok      = OMNI || (status_q[3:0] == CHANNEL);

`ifdef MIDI_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q;
    logic          pending_q;
    logic          byte_live;
    logic          timer_run;

    assign byte_live   = rx_valid && (rx_byte[7:3] != 5'b11111);
    assign timer_run   = pending_q && !byte_live;
    assign timeout_hit = timer_run && (timer_q == '0);

    // pending marks a partially received message: status seen, or first of two data bytes held.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else if (byte_live) begin
            timer_q   <= TW'(TIMEOUT_CYCLES);
            pending_q <= byte_status ||
                         (byte_data && (state_q == WAIT_D1) && !one_byte_msg);
        end else if (timer_run) begin
            if (timer_q == '0) begin
                pending_q <= 1'b0;
            end else begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= '0;
            d1_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        if (byte_sys) begin
            state_d  = SKIP;
            status_d = '0;
        end else if (byte_status) begin
            state_d  = WAIT_D1;
            status_d = rx_byte;
        end else if (byte_data) begin
            case (state_q)
                WAIT_D1: begin
                    d1_d = rx_byte[6:0];
                    if (!one_byte_msg) begin
                        state_d = WAIT_D2;
                    end
                end
                WAIT_D2: state_d = WAIT_D1;
                default: state_d = state_q;
            endcase
        end else if (timeout_hit) begin
            state_d = WAIT_D1;
        end
    end

    always_comb begin
        ev_note = 1'b0;
        ev_on   = 1'b0;
        ev_off  = 1'b0;
        ev_err  = 1'b0;
        if (byte_data && (state_q == WAIT_D2) && note_msg && chan_ok) begin
            ev_note = 1'b1;
            // Note On with velocity 0 is the conventional Note Off.
            if (status_q[4] && (rx_byte[6:0] != 7'd0)) begin
                ev_on = 1'b1;
            end else begin
                ev_off = 1'b1;
            end
        end
        if ((byte_data && (state_q == IDLE)) || timeout_hit) begin
            ev_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            msg_error <= 1'b0;
            note      <= '0;
            velocity  <= '0;
            channel   <= '0;
            gate      <= 1'b0;
            gate_note <= '0;
        end else begin
            note_on   <= ev_on;
            note_off  <= ev_off;
            msg_error <= ev_err;
            if (ev_note) begin
                note     <= d1_q;
                velocity <= rx_byte[6:0];
                channel  <= status_q[3:0];
            end
            // Monophonic: a new note steals the gate; only releasing the sounding note closes it.
            if (ev_on) begin
                gate      <= 1'b1;
                gate_note <= d1_q;
            end else if (ev_off && (d1_q == gate_note)) begin
                gate <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_parser.sv
// Bench for midi_note_parser: directed vector table, hand-written corner sequences, random bytes vs model.
module tb_midi_note_parser;

    typedef struct packed {
        logic       on;
        logic       off;
        logic       err;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] ch;
        logic       gate;
        logic [6:0] gnote;
    } exp_t;

    typedef struct {
        logic       vld;
        logic [7:0] b;
        exp_t       e;
        logic       on1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    logic       on0, off0, err0, gate0;
    logic [6:0] note0, vel0, gn0;
    logic [3:0] ch0;
    logic       on1, off1, err1, gate1;
    logic [6:0] note1, vel1, gn1;
    logic [3:0] ch1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: running status, collected data bytes, sysex skip flag.
    logic [7:0] rs;
    bit         rs_vld;
    bit         skip;
    logic [7:0] dq[$];
    exp_t       m[2];

    always #5 clk = ~clk;

    midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0), .TIMEOUT_CYCLES(20)) u_dut0 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .note_on(on0), .note_off(off0), .note(note0), .velocity(vel0),
        .channel(ch0), .gate(gate0), .gate_note(gn0), .msg_error(err0)
    );

    midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1), .TIMEOUT_CYCLES(20)) u_dut1 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .note_on(on1), .note_off(off1), .note(note1), .velocity(vel1),
        .channel(ch1), .gate(gate1), .gate_note(gn1), .msg_error(err1)
    );

    function automatic exp_t got(input int i);
        exp_t g;
        if (i == 0) g = {on0, off0, err0, note0, vel0, ch0, gate0, gn0};
        else        g = {on1, off1, err1, note1, vel1, ch1, gate1, gn1};
        return g;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("on=%b off=%b err=%b note=%h vel=%h ch=%h gate=%b gnote=%h",
                         x.on, x.off, x.err, x.note, x.vel, x.ch, x.gate, x.gnote);
    endfunction

    task automatic compare(input string name, input exp_t g, input exp_t e);
        n_cmp++;
        if (g !== e || (g.on && g.off)) begin
            n_bad++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(g), fmt(e));
        end
    endtask

    function automatic void model_reset();
        rs_vld = 1'b0;
        rs     = 8'h00;
        skip   = 1'b0;
        dq.delete();
        m[0] = '0;
        m[1] = '0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b);
        int need;
        bit acc;
        for (int i = 0; i < 2; i++) begin
            m[i].on  = 1'b0;
            m[i].off = 1'b0;
            m[i].err = 1'b0;
        end
        if (!v || b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            rs_vld = 1'b0;
            skip   = 1'b1;
            dq.delete();
            return;
        end
        if (b >= 8'h80) begin
            rs     = b;
            rs_vld = 1'b1;
            skip   = 1'b0;
            dq.delete();
            return;
        end
        if (skip) return;
        if (!rs_vld) begin
            m[0].err = 1'b1;
            m[1].err = 1'b1;
            return;
        end
        dq.push_back(b);
        need = (rs >= 8'hC0 && rs < 8'hE0) ? 1 : 2;
        if (dq.size() < need) return;
        if (rs < 8'hA0) begin
            for (int i = 0; i < 2; i++) begin
                acc = (i == 1) || (rs % 16 == 0);
                if (acc) begin
                    m[i].note = dq[0][6:0];
                    m[i].vel  = dq[1][6:0];
                    m[i].ch   = rs[3:0];
                    if (rs >= 8'h90 && dq[1] != 8'h00) begin
                        m[i].on    = 1'b1;
                        m[i].gate  = 1'b1;
                        m[i].gnote = dq[0][6:0];
                    end else begin
                        m[i].off = 1'b1;
                        if (dq[0][6:0] == m[i].gnote) m[i].gate = 1'b0;
                    end
                end
            end
        end
        dq.delete();
    endfunction

    task automatic step(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        model_step(v, b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic on, input logic off,
                                input logic err, input logic [6:0] nt, input logic [6:0] vl,
                                input logic [3:0] ch, input logic g, input logic [6:0] gn,
                                input logic o1);
        vec_t t;
        t.vld = v;
        t.b   = b;
        t.e   = '{on, off, err, nt, vl, ch, g, gn};
        t.on1 = o1;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[$];
        exp_t       e;
        logic [7:0] b;
        int         r, errs, first;
        bit         last_rt;

        @(negedge clk);
        do_reset();
        compare("reset dut0", got(0), '0);
        compare("reset dut1", got(1), '0);

        //            vld   byte  on off err note  vel   ch gate gnote on1
        tbl.push_back(mk(1, 8'h90, 0, 0, 0, 7'h00, 7'h00, 0, 0, 7'h00, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h00, 7'h00, 0, 0, 7'h00, 0));
        tbl.push_back(mk(1, 8'h64, 1, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h40, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h50, 1, 0, 0, 7'h40, 7'h50, 0, 1, 7'h40, 1));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h40, 7'h50, 0, 1, 7'h40, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 7'h3C, 7'h00, 0, 1, 7'h40, 0));
        tbl.push_back(mk(1, 8'h80, 0, 0, 0, 7'h3C, 7'h00, 0, 1, 7'h40, 0));
        tbl.push_back(mk(1, 8'h40, 0, 0, 0, 7'h3C, 7'h00, 0, 1, 7'h40, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 7'h40, 7'h00, 0, 0, 7'h40, 0));
        tbl.push_back(mk(1, 8'h90, 0, 0, 0, 7'h40, 7'h00, 0, 0, 7'h40, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h40, 7'h00, 0, 0, 7'h40, 0));
        tbl.push_back(mk(1, 8'hF8, 0, 0, 0, 7'h40, 7'h00, 0, 0, 7'h40, 0));
        tbl.push_back(mk(1, 8'h64, 1, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 1));
        tbl.push_back(mk(1, 8'hC0, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h64, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h91, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h64, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 1));
        tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h7E, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h7F, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'hF7, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h80, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 0, 1, 7'h3C, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 7'h3C, 7'h00, 0, 0, 7'h3C, 0));

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].b);
            compare($sformatf("vec%0d dut0", i), got(0), tbl[i].e);
            compare($sformatf("vec%0d dut1", i), got(1), m[1]);
            n_cmp++;
            if (on1 !== tbl[i].on1) begin
                n_bad++;
                $display("FAIL vec%0d omni note_on: got %b expected %b", i, on1, tbl[i].on1);
            end
        end
        if (got(1).ch !== 4'd1) begin
            // omni instance last event was 80 3C 00 on channel 0; channel 1 check happened at vec21
        end

        // Data with no running status after reset: two errors, no events.
        do_reset();
        e = '0;
        e.err = 1'b1;
        step(1, 8'h3C);
        compare("norun 3C", got(0), e);
        step(1, 8'h64);
        compare("norun 64", got(0), e);
        step(0, 8'h00);
        compare("norun idle", got(0), '0);

        // Reset between the data bytes of a note: event lost, gate cleared.
        step(1, 8'h90);
        step(1, 8'h40);
        step(1, 8'h64);
        compare("pre-reset on", got(0), m[0]);
        step(1, 8'h3C);
        do_reset();
        step(1, 8'h64);
        compare("rst mid-msg", got(0), e);

`ifdef MIDI_TIMEOUT_EN
        do_reset();
        step(1, 8'h90);
        step(1, 8'h3C);
        errs  = 0;
        first = -1;
        for (int i = 0; i < 25; i++) begin
            step(0, 8'h00);
            if (err0 === 1'b1) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (errs != 1 || first < 15) begin
            n_bad++;
            $display("FAIL timeout err: got %0d pulses first at %0d expected 1 pulse after idle 15", errs, first);
        end
        dq.delete();
        step(1, 8'h3C);
        step(1, 8'h64);
        compare("timeout resume", got(0), '{1'b1, 1'b0, 1'b0, 7'h3C, 7'h64, 4'd0, 1'b1, 7'h3C});
`endif

        do_reset();
        last_rt = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8 && !last_rt) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
                last_rt = 1'b1;
            end else begin
                last_rt = 1'b0;
                if (r < 11) begin
                    b = 8'hF0 + 8'($urandom_range(0, 7));
                end else if (r < 35) begin
                    case ($urandom_range(0, 8))
                        0, 1:    b = 8'h80;
                        2, 3, 4: b = 8'h90;
                        5:       b = 8'hA0;
                        6:       b = 8'hB0;
                        7:       b = 8'hC0 + 8'($urandom_range(0, 1) * 16);
                        default: b = 8'hE0;
                    endcase
                    b = b + 8'($urandom_range(0, 2));
                end else begin
                    case ($urandom_range(0, 4))
                        0:       b = 8'h00;
                        1:       b = 8'h3C;
                        2:       b = 8'h3D;
                        3:       b = 8'h40;
                        default: b = 8'($urandom_range(0, 127));
                    endcase
                end
            end
            step(1, b);
            compare($sformatf("rnd%0d byte %h dut0", k, b), got(0), m[0]);
            compare($sformatf("rnd%0d byte %h dut1", k, b), got(1), m[1]);
            repeat ($urandom_range(0, 2)) begin
                step(0, 8'h00);
                compare($sformatf("rnd%0d gap dut0", k), got(0), m[0]);
                compare($sformatf("rnd%0d gap dut1", k), got(1), m[1]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
